mips_dmem_responder: RTL and testbench
======================================

Name: mips_dmem_responder

Overview:
Responder end of the pipeline's MEM-stage data-memory interface. It accepts load/store requests (address, write data, rd/wr strobe) from the MEM stage through a valid/ready handshake and returns read data after a configurable number of wait states. It raises a stall request to the hazard logic while a request is in flight. Behind the same port it holds a word-addressed data RAM and a small memory-mapped register window (cycle counter, scratch, done/halt).

Parameters:
DEPTH_WORDS, 256, number of 32-bit RAM words; legal word index is 0..DEPTH_WORDS-1.
WAIT_CYCLES, 1, wait states between request acceptance and response (0..15).
MMIO_BASE, 32'hFFFF_0000, base byte address of the MMIO window; the window is 64 bytes.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
req_valid  in  1  MEM stage presents a request.
req_wr  in  1  1 = store, 0 = load.
req_addr  in  32  byte address.
req_wdata  in  32  store data.
req_ready  out  1  responder can accept a request.
rsp_valid  out  1  one-cycle pulse: response and read data valid.
rsp_rdata  out  32  load data; 0 for stores and errors.
rsp_err  out  1  qualifies rsp_valid; the access was illegal.
stall_req  out  1  freeze request to the hazard unit.
done  out  1  sticky "program finished" flag.
done_code  out  8  exit code written with done.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall_req=0.
  - done=0, done_code=0.
  - Cycle counter and scratch cleared.
  - RAM contents are not reset.
- FSM states IDLE, WAIT, RESP.
  - IDLE: req_ready=1. A request is accepted when req_valid=1 at a clock edge.
    - If WAIT_CYCLES=0, go to RESP; otherwise go to WAIT with the wait counter loaded to WAIT_CYCLES-1.
    - Address, wr and wdata are registered on acceptance.
  - WAIT: req_ready=0. The wait counter decrements each cycle; go to RESP when it is 0.
  - RESP: rsp_valid=1 for exactly one cycle; always returns to IDLE. A new request can be accepted no earlier than the cycle after RESP.
- Latency: acceptance edge to rsp_valid is WAIT_CYCLES+1 cycles.
- stall_req (combinational) = (IDLE & req_valid) | WAIT. It is 0 in RESP, so the pipeline advances on the response cycle. The requester holds req_* stable while stall_req=1.
- Store commit:
  - The RAM or register write happens on the edge that leaves the last pre-RESP state.
  - Illegal stores commit nothing.
- Load data is captured on the same edge and held on rsp_rdata through RESP. rsp_rdata returns to 0 in IDLE.
- Errors (rsp_err=1, rdata=0, no side effects):
  - req_addr[1:0] != 0.
  - RAM word index >= DEPTH_WORDS.
  - MMIO offset unmapped.
  - Write to a read-only register.
- MMIO map (offset from MMIO_BASE):
  - 0x00 CYCLES (read-only): free-running 32-bit counter; increments every cycle; wraps 0xFFFF_FFFF -> 0.
  - 0x04 SCRATCH (read/write).
  - 0x08 DONE (read/write):
    - Writing sets done=1 and done_code=wdata[7:0].
    - Once done=1, further writes are ignored without error; done stays set until reset.
    - Read returns {23'b0, done, done_code}.
- Addresses outside both RAM and MMIO are errors.
- A reset during WAIT or RESP abandons the request: no commit, no response.

Optional Feature:
DMEM_STATS_EN. When defined:
- 0x0C LOADS: read-only count of legal completed loads.
- 0x10 STORES: read-only count of legal completed stores.
- Both are 32-bit, wrap, count at RESP, and are cleared by reset.
When undefined, 0x0C and 0x10 are unmapped and return an error.

Decomposition:
- Package mips_mem_pkg: FSM state enum; MMIO offset constants (OFF_CYCLES, OFF_SCRATCH, OFF_DONE, OFF_LOADS, OFF_STORES); MMIO_WINDOW_BYTES.
- Sub-module mips_dmem_mmio: MMIO register file, counters, done logic and address decode.
- The top level keeps the FSM, RAM and the error merge.

Test Plan:
1. WAIT_CYCLES=2: store 0xDEADBEEF to 0x10, then load 0x10 -> rsp_valid 3 cycles after each accept, rdata=0xDEADBEEF, stall_req high for exactly 3 cycles per access.
2. WAIT_CYCLES=0: back-to-back loads with req_valid held -> accepts separated by 2 cycles, no double response.
3. Load 0x12 (misaligned) and load 0x400 (index 256) -> rsp_err=1, rdata=0; preceding RAM content unchanged.
4. Store 0x0000_002A to MMIO_BASE+8 -> done=1, done_code=0x2A; later store 0x55 -> still 0x2A; read returns 0x0000_012A.
5. Read CYCLES twice, 10 cycles apart -> difference 10 + access latency; force counter to 0xFFFF_FFFF -> wraps to 0.
6. Assert reset mid-WAIT on a store to 0x20 -> no write committed, outputs at reset values; with DMEM_STATS_EN, LOADS/STORES = 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and MMIO map for the MEM-stage data-memory responder.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    localparam logic [5:0] OFF_CYCLES  = 6'h00;
    localparam logic [5:0] OFF_SCRATCH = 6'h04;
    localparam logic [5:0] OFF_DONE    = 6'h08;
    localparam logic [5:0] OFF_LOADS   = 6'h0C;
    localparam logic [5:0] OFF_STORES  = 6'h10;

    localparam int unsigned MMIO_WINDOW_BYTES = 64;

endpackage

// File: rtl/mips_dmem_mmio.sv
// MMIO register window: cycle counter, scratch, sticky done/halt and optional
// access statistics (enabled with DMEM_STATS_EN).
module mips_dmem_mmio
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  offset,
    input  logic        wr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        cnt_load,
    input  logic        cnt_store,
    output logic [31:0] rdata,
    output logic        err,
    output logic        done,
    output logic [7:0]  done_code
);

    logic [31:0] cycles;
    logic [31:0] scratch;
`ifdef DMEM_STATS_EN
    logic [31:0] loads;
    logic [31:0] stores;
`endif

    // Read-only registers flag an error on store; unmapped offsets always do.
    always_comb begin
        rdata = '0;
        err   = 1'b0;
        case (offset)
            OFF_CYCLES: begin
                rdata = cycles;
                err   = wr;
            end
            OFF_SCRATCH: rdata = scratch;
            OFF_DONE:    rdata = {23'b0, done, done_code};
`ifdef DMEM_STATS_EN
            OFF_LOADS: begin
                rdata = loads;
                err   = wr;
            end
            OFF_STORES: begin
                rdata = stores;
                err   = wr;
            end
`endif
            default: err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles    <= '0;
            scratch   <= '0;
            done      <= 1'b0;
            done_code <= '0;
        end else begin
            cycles <= cycles + 32'd1;
            if (we && offset == OFF_SCRATCH) begin
                scratch <= wdata;
            end
            if (we && offset == OFF_DONE && !done) begin
                done      <= 1'b1;
                done_code <= wdata[7:0];
            end
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loads  <= '0;
            stores <= '0;
        end else begin
            if (cnt_load) begin
                loads <= loads + 32'd1;
            end
            if (cnt_store) begin
                stores <= stores + 32'd1;
            end
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = cnt_load ^ cnt_store;
`endif

endmodule

// File: rtl/mips_dmem_responder.sv
// MEM-stage data-memory responder: request FSM with wait states, word RAM and
// MMIO window. Optional statistics registers are built with DMEM_STATS_EN.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall_req,
    output logic        done,
    output logic [7:0]  done_code
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_t state;
    logic [3:0]  wait_cnt;
    logic        acc_wr;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    logic        cur_wr;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        commit;
    logic        ram_hit;
    logic        mmio_hit;
    logic        mmio_err;
    logic        acc_err;
    logic        ram_we;
    logic        mmio_we;
    logic [31:0] mmio_off;
    logic [31:0] mmio_rdata;
    logic [31:0] ram_rdata;
    logic [31:0] load_data;
    logic [IDX_W-1:0] ram_idx;

    logic [31:0] ram [DEPTH_WORDS];

    assign stall_req = (state == IDLE && req_valid) || state == WAIT;

    // With zero wait states the commit edge is the acceptance edge, so the
    // decode must look at the live request rather than the captured copy.
    always_comb begin
        if (state == IDLE) begin
            cur_wr    = req_wr;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_wr    = acc_wr;
            cur_addr  = acc_addr;
            cur_wdata = acc_wdata;
        end
    end

    assign commit = (state == IDLE && req_valid && WAIT_CYCLES == 0)
                 || (state == WAIT && wait_cnt == '0);

    assign ram_idx   = cur_addr[IDX_W+1:2];
    assign ram_hit   = {2'b00, cur_addr[31:2]} < 32'(DEPTH_WORDS);
    assign mmio_off  = cur_addr - MMIO_BASE;
    assign mmio_hit  = !ram_hit && (mmio_off < 32'(MMIO_WINDOW_BYTES));
    assign acc_err   = (cur_addr[1:0] != 2'b00) || !(ram_hit || mmio_hit)
                    || (mmio_hit && mmio_err);
    assign ram_rdata = ram[ram_idx];
    assign load_data = ram_hit ? ram_rdata : mmio_rdata;
    assign ram_we    = reset && commit && cur_wr && ram_hit && !acc_err;
    assign mmio_we   = commit && cur_wr && mmio_hit && !acc_err;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= cur_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            acc_wr    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        acc_wr    <= req_wr;
                        acc_addr  <= req_addr;
                        acc_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || cur_wr) ? '0 : load_data;
            end
        end
    end

    mips_dmem_mmio u_mmio (
        .clk       (clk),
        .reset     (reset),
        .offset    (mmio_off[5:0]),
        .wr        (cur_wr),
        .wdata     (cur_wdata),
        .we        (mmio_we),
        .cnt_load  (state == RESP && !rsp_err && !acc_wr),
        .cnt_store (state == RESP && !rsp_err && acc_wr),
        .rdata     (mmio_rdata),
        .err       (mmio_err),
        .done      (done),
        .done_code (done_code)
    );

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench for mips_dmem_responder: one instance with two wait states,
// one with none.
module tb_mips_dmem_responder;

    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        v2, v0, wr;
    logic [31:0] addr, wdata;

    logic        rdy2, rv2, err2, st2, done2;
    logic [31:0] rd2;
    logic [7:0]  dc2;
    logic        rdy0, rv0, err0, st0, done0;
    logic [31:0] rd0;
    logic [7:0]  dc0;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .MMIO_BASE(MB)) d2 (
        .clk(clk), .reset(reset), .req_valid(v2), .req_wr(wr), .req_addr(addr),
        .req_wdata(wdata), .req_ready(rdy2), .rsp_valid(rv2), .rsp_rdata(rd2),
        .rsp_err(err2), .stall_req(st2), .done(done2), .done_code(dc2)
    );

    mips_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .MMIO_BASE(MB)) d0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_wr(wr), .req_addr(addr),
        .req_wdata(wdata), .req_ready(rdy0), .rsp_valid(rv0), .rsp_rdata(rd0),
        .rsp_err(err0), .stall_req(st0), .done(done0), .done_code(dc0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request on the chosen instance; lat counts cycles from the drive
    // cycle to the response cycle, stalls counts cycles with stall_req high.
    task automatic access(input bit on0, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rdata,
                          output logic err, output int lat, output int stalls);
        bit got;
        got    = 1'b0;
        lat    = 0;
        stalls = 0;
        rdata  = '0;
        err    = 1'b1;
        @(negedge clk);
        wr    = w;
        addr  = a;
        wdata = d;
        if (on0) v0 = 1'b1;
        else     v2 = 1'b1;
        for (int c = 0; c < 24 && !got; c++) begin
            #1;
            if (on0 ? st0 : st2) stalls++;
            if (on0 ? rv0 : rv2) begin
                got   = 1'b1;
                lat   = c;
                rdata = on0 ? rd0 : rd2;
                err   = on0 ? err0 : err2;
                v0    = 1'b0;
                v2    = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        v0 = 1'b0;
        v2 = 1'b0;
        check("rsp_seen", 32'(got), 32'd1);
        @(negedge clk);
        #1;
        check("rsp_pulse", 32'(on0 ? rv0 : rv2), 32'd0);
        check("rdata_idle", on0 ? rd0 : rd2, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, c1;
        logic        er;
        int          lat, stl;

        reset = 1'b1;
        v2 = 1'b0; v0 = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(rdy2), 32'd1);
        check("rst_valid", 32'(rv2), 32'd0);
        check("rst_rdata", rd2, 32'd0);
        check("rst_err", 32'(err2), 32'd0);
        check("rst_stall", 32'(st2), 32'd0);
        check("rst_done", 32'(done2), 32'd0);
        check("rst_code", 32'(dc2), 32'd0);
        check("rst_ready0", 32'(rdy0), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // store then load with two wait states
        access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat, stl);
        check("st_lat", 32'(lat), 32'd3);
        check("st_stalls", 32'(stl), 32'd3);
        check("st_err", 32'(er), 32'd0);
        check("st_rdata", rd, 32'd0);
        access(0, 1'b0, 32'h10, 32'h0, rd, er, lat, stl);
        check("ld_lat", 32'(lat), 32'd3);
        check("ld_stalls", 32'(stl), 32'd3);
        check("ld_err", 32'(er), 32'd0);
        check("ld_rdata", rd, 32'hDEAD_BEEF);

        // zero wait states: back-to-back loads with req_valid held
        access(1, 1'b1, 32'h10, 32'hCAFE_0001, rd, er, lat, stl);
        check("z_st_lat", 32'(lat), 32'd1);
        check("z_st_stalls", 32'(stl), 32'd1);
        @(negedge clk);
        wr = 1'b0; addr = 32'h10; v0 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("b2b_valid%0d", c), 32'(rv0), 32'(c % 2));
            check($sformatf("b2b_ready%0d", c), 32'(rdy0), 32'(1 - c % 2));
            if (c % 2 == 1) check("b2b_rdata", rd0, 32'hCAFE_0001);
            @(negedge clk);
        end
        v0 = 1'b0;
        #1;
        check("b2b_no_extra", 32'(rv0), 32'd0);
        @(negedge clk);
        #1;
        check("b2b_no_extra2", 32'(rv0), 32'd0);

        // RAM error boundaries
        access(0, 1'b0, 32'h12, 32'h0, rd, er, lat, stl);
        check("misal_err", 32'(er), 32'd1);
        check("misal_rdata", rd, 32'd0);
        access(0, 1'b0, 32'h400, 32'h0, rd, er, lat, stl);
        check("oob_ld_err", 32'(er), 32'd1);
        check("oob_ld_rdata", rd, 32'd0);
        access(0, 1'b1, 32'h400, 32'h1234, rd, er, lat, stl);
        check("oob_st_err", 32'(er), 32'd1);
        access(0, 1'b1, 32'h12, 32'h5555_5555, rd, er, lat, stl);
        check("misal_st_err", 32'(er), 32'd1);
        access(0, 1'b0, 32'h10, 32'h0, rd, er, lat, stl);
        check("ram_kept", rd, 32'hDEAD_BEEF);
        access(0, 1'b1, 32'h3FC, 32'h0BAD_F00D, rd, er, lat, stl);
        check("last_st_err", 32'(er), 32'd0);
        access(0, 1'b0, 32'h3FC, 32'h0, rd, er, lat, stl);
        check("last_ld", rd, 32'h0BAD_F00D);

        // done register and other MMIO
        access(0, 1'b1, MB + 32'h8, 32'h0000_002A, rd, er, lat, stl);
        check("done_st_err", 32'(er), 32'd0);
        check("done_flag", 32'(done2), 32'd1);
        check("done_code", 32'(dc2), 32'h2A);
        access(0, 1'b1, MB + 32'h8, 32'h0000_0055, rd, er, lat, stl);
        check("done2_err", 32'(er), 32'd0);
        check("done_sticky", 32'(dc2), 32'h2A);
        access(0, 1'b0, MB + 32'h8, 32'h0, rd, er, lat, stl);
        check("done_read", rd, 32'h0000_012A);
        access(0, 1'b1, MB + 32'h4, 32'hA5A5_1234, rd, er, lat, stl);
        access(0, 1'b0, MB + 32'h4, 32'h0, rd, er, lat, stl);
        check("scratch", rd, 32'hA5A5_1234);
        access(0, 1'b1, MB, 32'h0, rd, er, lat, stl);
        check("ro_cycles_err", 32'(er), 32'd1);
        access(0, 1'b0, MB + 32'h14, 32'h0, rd, er, lat, stl);
        check("unmapped_err", 32'(er), 32'd1);
        access(0, 1'b0, MB + 32'h40, 32'h0, rd, er, lat, stl);
        check("past_window_err", 32'(er), 32'd1);
        check("past_window_rd", rd, 32'd0);

        // cycle counter: drives 15 cycles apart, then wrap
        access(0, 1'b0, MB, 32'h0, rd, er, lat, stl);
        c1 = rd;
        repeat (10) @(negedge clk);
        access(0, 1'b0, MB, 32'h0, rd, er, lat, stl);
        check("cyc_delta", rd - c1, 32'd15);
        @(negedge clk);
        force d2.u_mmio.cycles = 32'hFFFF_FFFF;
        @(negedge clk);
        release d2.u_mmio.cycles;
        @(negedge clk);
        #1;
        check("cyc_wrap", d2.u_mmio.cycles, 32'd0);
        access(0, 1'b0, MB, 32'h0, rd, er, lat, stl);
        check("cyc_after_wrap", rd, 32'd3);

        // reset in the middle of a store's wait states
        access(0, 1'b1, 32'h20, 32'h1111_2222, rd, er, lat, stl);
        @(negedge clk);
        wr = 1'b1; addr = 32'h20; wdata = 32'h0000_0099; v2 = 1'b1;
        @(negedge clk);
        #1;
        check("mid_wait_stall", 32'(st2), 32'd1);
        check("mid_wait_ready", 32'(rdy2), 32'd0);
        reset = 1'b0;
        v2 = 1'b0;
        #1;
        check("ar_ready", 32'(rdy2), 32'd1);
        check("ar_valid", 32'(rv2), 32'd0);
        check("ar_rdata", rd2, 32'd0);
        check("ar_err", 32'(err2), 32'd0);
        check("ar_stall", 32'(st2), 32'd0);
        check("ar_done", 32'(done2), 32'd0);
        check("ar_code", 32'(dc2), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("ar_no_rsp", 32'(rv2), 32'd0);
        reset = 1'b1;
        access(0, 1'b0, 32'h20, 32'h0, rd, er, lat, stl);
        check("ar_no_commit", rd, 32'h1111_2222);
`ifdef DMEM_STATS_EN
        access(0, 1'b0, MB + 32'hC, 32'h0, rd, er, lat, stl);
        check("loads_err", 32'(er), 32'd0);
        check("loads_after_rst", rd, 32'd1);
        access(0, 1'b0, MB + 32'h10, 32'h0, rd, er, lat, stl);
        check("stores_err", 32'(er), 32'd0);
        check("stores_after_rst", rd, 32'd0);
        access(0, 1'b1, MB + 32'hC, 32'h7, rd, er, lat, stl);
        check("loads_ro_err", 32'(er), 32'd1);
`else
        access(0, 1'b0, MB + 32'hC, 32'h0, rd, er, lat, stl);
        check("loads_unmapped", 32'(er), 32'd1);
        access(0, 1'b0, MB + 32'h10, 32'h0, rd, er, lat, stl);
        check("stores_unmapped", 32'(er), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
